// File: rtl/fetch_if_id_stage_pkg.sv
// rtl/fetch_if_id_stage_pkg.sv - shared widths, bubble instruction and fetch state encodings
package fetch_if_id_stage_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_if_id_stage_if_id_reg.sv
// rtl/fetch_if_id_stage_if_id_reg.sv - IF/ID pipeline register with load, flush and reset
module fetch_if_id_stage_if_id_reg
    import fetch_if_id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;

    // Flush outranks load; the PC field is left as-is since it is meaningless once invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// rtl/fetch_if_id_stage.sv - fetch sequencer driving instruction memory and the IF/ID register
module fetch_if_id_stage
    import fetch_if_id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    input  logic            flush,
    input  logic            id_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            pc_write,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst
);

    fetch_state_e    state_q;
    logic            imem_req_q;
    logic [XLEN-1:0] imem_addr_q;
    logic            pc_write_q;
    logic            drop_q;
    logic [XLEN-1:0] hold_pc_q;
    logic [XLEN-1:0] hold_inst_q;

    logic            ifid_free;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_inst;

    always_comb begin
        ifid_free = !id_stall || !id_valid;
        ifid_load = 1'b0;
        ifid_pc   = hold_pc_q;
        ifid_inst = hold_inst_q;
        if (!flush) begin
            case (state_q)
                FS_WAIT: begin
                    if (imem_ack && !drop_q && ifid_free) begin
                        ifid_load = 1'b1;
                        ifid_pc   = imem_addr_q;
                        ifid_inst = imem_rdata;
                    end
                end
                FS_HOLD: ifid_load = ifid_free;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FS_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            pc_write_q  <= 1'b0;
            drop_q      <= 1'b0;
            hold_pc_q   <= '0;
            hold_inst_q <= NOP_INST;
        end else begin
            // The PC stage moves only on an IF/ID load or a redirect.
            pc_write_q <= flush || ifid_load;
            if (flush) begin
                case (state_q)
                    FS_WAIT: begin
                        if (imem_ack) begin
                            imem_req_q <= 1'b0;
                            drop_q     <= 1'b0;
                            state_q    <= FS_IDLE;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end
                    default: state_q <= FS_IDLE;
                endcase
            end else begin
                case (state_q)
                    FS_IDLE: begin
                        imem_addr_q <= pc_if;
                        imem_req_q  <= 1'b1;
                        state_q     <= FS_WAIT;
                    end
                    FS_WAIT: begin
                        if (imem_ack) begin
                            imem_req_q <= 1'b0;
                            if (drop_q) begin
                                drop_q  <= 1'b0;
                                state_q <= FS_IDLE;
                            end else if (ifid_free) begin
                                state_q <= FS_IDLE;
                            end else begin
                                hold_pc_q   <= imem_addr_q;
                                hold_inst_q <= imem_rdata;
                                state_q     <= FS_HOLD;
                            end
                        end
                    end
                    FS_HOLD: if (ifid_free) state_q <= FS_IDLE;
                    default: state_q <= FS_IDLE;
                endcase
            end
        end
    end

    fetch_if_id_stage_if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .load_i  (ifid_load),
        .pc_i    (ifid_pc),
        .inst_i  (ifid_inst),
        .valid_o (id_valid),
        .pc_o    (id_pc),
        .inst_o  (id_inst)
    );

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign pc_write  = pc_write_q;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// tb/tb_fetch_if_id_stage.sv - directed vector table plus randomized run against a transaction-level model
module tb_fetch_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        flush;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_write;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_if_id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .pc_if      (pc_if),
        .flush      (flush),
        .id_stall   (id_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_write   (pc_write),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst)
    );

    typedef struct {
        logic        rst, flush, stall, ack;
        logic [31:0] rdata, pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_pcw, e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic s, input logic a,
                                input logic [31:0] rd, input logic [31:0] p,
                                input logic q, input logic [31:0] ad, input logic w,
                                input logic v, input logic [31:0] ipc, input logic [31:0] ins);
        vec_t t;
        t.rst = r; t.flush = f; t.stall = s; t.ack = a; t.rdata = rd; t.pc = p;
        t.e_req = q; t.e_addr = ad; t.e_pcw = w; t.e_valid = v; t.e_pc = ipc; t.e_inst = ins;
        return t;
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic f, input logic s, input logic a,
                         input logic [31:0] rd, input logic [31:0] p);
        @(negedge clk);
        rst = r; flush = f; id_stall = s; imem_ack = a; imem_rdata = rd; pc_if = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int step, input logic q, input logic [31:0] ad,
                             input logic w, input logic v, input logic [31:0] ipc, input logic [31:0] ins);
        check({tag, ".imem_req"},  step, 32'(imem_req),  32'(q));
        check({tag, ".imem_addr"}, step, imem_addr,      ad);
        check({tag, ".pc_write"},  step, 32'(pc_write),  32'(w));
        check({tag, ".id_valid"},  step, 32'(id_valid),  32'(v));
        check({tag, ".id_pc"},     step, id_pc,          ipc);
        check({tag, ".id_inst"},   step, id_inst,        ins);
    endtask

    // Transaction-level reference: one outstanding fetch, one parked instruction, one IF/ID slot.
    bit          m_fetching, m_dropping, m_parked, m_pcw, m_valid;
    logic [31:0] m_fetch_addr, m_park_pc, m_park_inst, m_pc, m_inst;

    task automatic model_step(input logic r, input logic f, input logic s, input logic a,
                              input logic [31:0] rd, input logic [31:0] p);
        bit slot_free;
        if (r) begin
            m_fetching = 0; m_dropping = 0; m_parked = 0; m_pcw = 0;
            m_valid = 0; m_fetch_addr = 0; m_pc = 0; m_inst = NOP;
            return;
        end
        slot_free = !s || !m_valid;
        m_pcw = 0;
        if (f) begin
            m_pcw = 1; m_valid = 0; m_inst = NOP; m_parked = 0;
            if (m_fetching && a) begin
                m_fetching = 0; m_dropping = 0;
            end else if (m_fetching) begin
                m_dropping = 1;
            end
        end else if (m_fetching) begin
            if (a) begin
                m_fetching = 0;
                if (m_dropping) m_dropping = 0;
                else if (slot_free) begin
                    m_valid = 1; m_pc = m_fetch_addr; m_inst = rd; m_pcw = 1;
                end else begin
                    m_parked = 1; m_park_pc = m_fetch_addr; m_park_inst = rd;
                end
            end
        end else if (m_parked) begin
            if (slot_free) begin
                m_parked = 0; m_valid = 1; m_pc = m_park_pc; m_inst = m_park_inst; m_pcw = 1;
            end
        end else begin
            m_fetching = 1; m_fetch_addr = p;
        end
    endtask

    initial begin
        rst = 1; flush = 0; id_stall = 0; imem_ack = 0; imem_rdata = 0; pc_if = 0;

        //             rst f s a  rdata          pc        req addr   pcw val id_pc  id_inst
        vecs.push_back(mk(1,0,0,0, 32'h0,        32'h0,    0, 32'h0,  0, 0, 32'h0,   NOP));
        vecs.push_back(mk(1,0,0,0, 32'h0,        32'h0,    0, 32'h0,  0, 0, 32'h0,   NOP));
        vecs.push_back(mk(1,0,0,0, 32'h0,        32'h0,    0, 32'h0,  0, 0, 32'h0,   NOP));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h0,    1, 32'h0,  0, 0, 32'h0,   NOP));
        vecs.push_back(mk(0,0,0,1, 32'h00500093, 32'h0,    0, 32'h0,  1, 1, 32'h0,   32'h00500093));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h4,    1, 32'h4,  0, 1, 32'h0,   32'h00500093));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h4,    1, 32'h4,  0, 1, 32'h0,   32'h00500093));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h4,    1, 32'h4,  0, 1, 32'h0,   32'h00500093));
        vecs.push_back(mk(0,0,0,1, 32'h00200113, 32'h4,    0, 32'h4,  1, 1, 32'h4,   32'h00200113));
        vecs.push_back(mk(0,0,1,0, 32'h0,        32'h8,    1, 32'h8,  0, 1, 32'h4,   32'h00200113));
        vecs.push_back(mk(0,0,1,1, 32'h00A00113, 32'h8,    0, 32'h8,  0, 1, 32'h4,   32'h00200113));
        vecs.push_back(mk(0,0,1,0, 32'h0,        32'h8,    0, 32'h8,  0, 1, 32'h4,   32'h00200113));
        vecs.push_back(mk(0,0,1,0, 32'h0,        32'h8,    0, 32'h8,  0, 1, 32'h4,   32'h00200113));
        vecs.push_back(mk(0,0,1,0, 32'h0,        32'h8,    0, 32'h8,  0, 1, 32'h4,   32'h00200113));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h8,    0, 32'h8,  1, 1, 32'h8,   32'h00A00113));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'hC,    1, 32'hC,  0, 1, 32'h8,   32'h00A00113));
        vecs.push_back(mk(0,1,0,0, 32'h0,        32'h100,  1, 32'hC,  1, 0, 32'h8,   NOP));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h100,  1, 32'hC,  0, 0, 32'h8,   NOP));
        vecs.push_back(mk(0,0,0,1, 32'hDEADBEEF, 32'h100,  0, 32'hC,  0, 0, 32'h8,   NOP));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h100,  1, 32'h100,0, 0, 32'h8,   NOP));
        vecs.push_back(mk(0,0,0,1, 32'h00300193, 32'h100,  0, 32'h100,1, 1, 32'h100, 32'h00300193));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h104,  1, 32'h104,0, 1, 32'h100, 32'h00300193));
        vecs.push_back(mk(0,1,1,1, 32'h12345678, 32'h104,  0, 32'h104,1, 0, 32'h100, NOP));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h200,  1, 32'h200,0, 0, 32'h100, NOP));
        vecs.push_back(mk(0,0,0,1, 32'h00400213, 32'h200,  0, 32'h200,1, 1, 32'h200, 32'h00400213));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h204,  1, 32'h204,0, 1, 32'h200, 32'h00400213));
        vecs.push_back(mk(1,0,0,0, 32'h0,        32'h204,  0, 32'h0,  0, 0, 32'h0,   NOP));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h0,    1, 32'h0,  0, 0, 32'h0,   NOP));
        vecs.push_back(mk(0,0,0,1, 32'h00100073, 32'h0,    0, 32'h0,  1, 1, 32'h0,   32'h00100073));
        vecs.push_back(mk(0,1,0,0, 32'h0,        32'h40,   0, 32'h0,  1, 0, 32'h0,   NOP));
        vecs.push_back(mk(0,1,0,0, 32'h0,        32'h40,   0, 32'h0,  1, 0, 32'h0,   NOP));
        vecs.push_back(mk(0,0,0,0, 32'h0,        32'h40,   1, 32'h40, 0, 0, 32'h0,   NOP));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].ack, vecs[i].rdata, vecs[i].pc);
            check_all("vec", i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pcw,
                      vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst);
        end

        model_step(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        check_all("rand", 0, m_fetching, m_fetch_addr, m_pcw, m_valid, m_pc, m_inst);
        for (int n = 1; n <= 3000; n++) begin
            logic        r, f, s, a;
            logic [31:0] rd, p;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 2) == 0);
            a  = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            rd = $urandom;
            p  = {$urandom_range(0, 1023), 2'b00};
            model_step(r, f, s, a, rd, p);
            apply(r, f, s, a, rd, p);
            check_all("rand", n, m_fetching, m_fetch_addr, m_pcw, m_valid, m_pc, m_inst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
